// File: rtl/wt_bcd_sep_seq.sv
// -----------------------------------------------------------------------------
// wt_bcd_sep_seq
//
// Sequential binary-to-BCD digit separator. It sits between the time/alarm
// counters and the 7-segment/LCD digit drivers. Each conversion uses
// shift-and-add-3 (double dabble) and consumes one input bit per clock.
//
// The conversion takes a fixed number of cycles, whatever the value:
//   - one accept edge in IDLE;
//   - IN_W edges in CONVERT;
//   - one FINISH edge, which publishes the result.
//
// Captured values above MAX_VAL are replaced by BLANK_CODE in every digit.
// When LZ_BLANK is set, leading zero digits are also replaced by BLANK_CODE.
//
// Parameters
//   IN_W       width of NUMBER (1..16)
//   DIGITS     number of BCD digits produced (1..5)
//   MAX_VAL    largest value converted normally (<= 10^DIGITS-1)
//   BLANK_CODE nibble the digit driver decodes as "segments off"
//   LZ_BLANK   1 = blank leading zero digits (ones digit never blanked)
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high, priority over START
//   START      conversion request, sampled only in IDLE
//   NUMBER     unsigned input value, captured on the accepting edge
//   BUSY       high while a conversion is in progress
//   DONE       one-cycle pulse when DIGIT_OUT/OVF are updated
//   DIGIT_OUT  packed digits, [3:0] = ones, [7:4] = tens, ...
//   OVF        last captured value exceeded MAX_VAL
// -----------------------------------------------------------------------------
module wt_bcd_sep_seq #(
    parameter int unsigned IN_W       = 7,
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned MAX_VAL    = 99,
    parameter logic [3:0]  BLANK_CODE = 4'd13,
    parameter bit          LZ_BLANK   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [IN_W-1:0]       NUMBER,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   DIGIT_OUT,
    output logic                  OVF
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    state_t             state;
    logic [IN_W-1:0]    shift_q;   // remaining input bits, MSB shifted out first
    logic [BCD_W-1:0]   bcd_q;     // BCD accumulator
    logic [CNT_W-1:0]   cnt_q;     // CONVERT edges still to go
    logic               big_q;     // captured value was above MAX_VAL

    logic [BCD_W-1:0]   bcd_adj;   // accumulator after the parallel +3 step
    logic [BCD_W-1:0]   bcd_lz;    // final accumulator with leading-zero blanking

    // Add-3 correction. Every nibble that is 5 or more gets +3 before the
    // shift, so that the shift carries it into the next decade.
    always_comb begin
        // NOTE: default every always_comb output first; a path that leaves a
        // bit unassigned infers a latch.
        bcd_adj = bcd_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking. Scan from the most significant digit downward.
    // The scan stops at the first non-zero digit and never touches digit 0.
    always_comb begin
        logic zeros_above;
        bcd_lz      = bcd_q;
        zeros_above = 1'b1;
        if (LZ_BLANK) begin
            for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
                if (zeros_above && (bcd_q[4*d +: 4] == 4'd0)) begin
                    bcd_lz[4*d +: 4] = BLANK_CODE;
                end else begin
                    zeros_above = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            big_q     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DIGIT_OUT <= '0;
            OVF       <= 1'b0;
        end else begin
            // NOTE: all state is updated with non-blocking assignments. Every
            // read in this block therefore sees the pre-edge value.
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        shift_q <= NUMBER;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(IN_W);
                        // Range check on the captured value; NUMBER may change later.
                        big_q   <= (32'(NUMBER) > MAX_VAL);
                        BUSY    <= 1'b1;
                        state   <= CONVERT;
                    end
                end

                CONVERT: begin
                    // {bcd, shift} <<= 1, with the adjusted accumulator.
                    // Out-of-range values may lose the top BCD bit here. That
                    // is harmless because such results are blanked in FINISH.
                    bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[IN_W-1]};
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    if (big_q) begin
                        DIGIT_OUT <= {DIGITS{BLANK_CODE}};
                        OVF       <= 1'b1;
                    end else begin
                        DIGIT_OUT <= bcd_lz;
                        OVF       <= 1'b0;
                    end
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wt_bcd_sep_seq.sv
// -----------------------------------------------------------------------------
// tb_wt_bcd_sep_seq
//
// Self-checking bench for wt_bcd_sep_seq. It uses three instances:
//   - dut   : default parameters;
//   - dut_lz: defaults with leading-zero blanking;
//   - dut_w : 3 digits, 10-bit input, MAX_VAL = 999, with blanking.
//
// Expected digits come from a decimal reference model that uses division and
// modulo. Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wt_bcd_sep_seq;

    localparam int TIMEOUT = 40;
    localparam logic [3:0] BLK = 4'd13;

    logic        clk = 1'b0;
    logic        rst;

    // default instance
    logic        start;
    logic [6:0]  number;
    logic        busy, done, ovf;
    logic [7:0]  digit_out;

    // LZ_BLANK=1, otherwise defaults
    logic        start_lz;
    logic [6:0]  number_lz;
    logic        busy_lz, done_lz, ovf_lz;
    logic [7:0]  digit_lz;

    // DIGITS=3, IN_W=10, MAX_VAL=999, LZ_BLANK=1
    logic        start_w;
    logic [9:0]  number_w;
    logic        busy_w, done_w, ovf_w;
    logic [11:0] digit_w;

    int vec     = 0;
    int miscmp  = 0;

    always #5 clk = ~clk;

    wt_bcd_sep_seq dut (
        .CLK(clk), .RST(rst), .START(start), .NUMBER(number),
        .BUSY(busy), .DONE(done), .DIGIT_OUT(digit_out), .OVF(ovf)
    );

    wt_bcd_sep_seq #(.LZ_BLANK(1'b1)) dut_lz (
        .CLK(clk), .RST(rst), .START(start_lz), .NUMBER(number_lz),
        .BUSY(busy_lz), .DONE(done_lz), .DIGIT_OUT(digit_lz), .OVF(ovf_lz)
    );

    wt_bcd_sep_seq #(.IN_W(10), .DIGITS(3), .MAX_VAL(999), .LZ_BLANK(1'b1)) dut_w (
        .CLK(clk), .RST(rst), .START(start_w), .NUMBER(number_w),
        .BUSY(busy_w), .DONE(done_w), .DIGIT_OUT(digit_w), .OVF(ovf_w)
    );

    // Reference model:
    //   - values above maxv give the blank code in every digit;
    //   - otherwise each digit is (v / 10^i) % 10;
    //   - with lz set, leading zero digits above the ones digit become blanks.
    function automatic logic [19:0] ref_model(input int unsigned v, input int digits,
                                              input int unsigned maxv, input bit lz);
        logic [19:0] r;
        int unsigned p;
        r = '0;
        if (v > maxv) begin
            for (int i = 0; i < digits; i++) r[4*i +: 4] = BLK;
            return r;
        end
        p = 1;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        if (lz) begin
            for (int i = digits - 1; i >= 1; i--) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = BLK;
                else break;
            end
        end
        return r;
    endfunction

    // One conversion on the default instance.
    //   - lat counts clock edges after the accepting edge until DONE is seen.
    //   - busy_cnt counts the sampled cycles with BUSY high.
    //   - NUMBER is scrambled right after capture to prove it is not reused.
    task automatic run_conv(input logic [6:0] n, output logic [7:0] dig,
                            output logic ov, output int lat, output int busy_cnt);
        @(negedge clk);
        number = n;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        number   = 7'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        dig = digit_out;
        ov  = ovf;
        if (lat >= TIMEOUT) begin
            vec++; miscmp++;
            $display("FAIL done_timeout n=%0d: no DONE within %0d cycles", n, TIMEOUT);
        end
    endtask

    // One conversion on dut_lz (which=0) or dut_w (which=1).
    task automatic run_alt(input int which, input int unsigned n,
                           output logic [11:0] dig, output int lat);
        @(negedge clk);
        if (which == 0) begin number_lz = 7'(n);  start_lz = 1'b1; end
        else            begin number_w  = 10'(n); start_w  = 1'b1; end
        @(negedge clk);
        start_lz = 1'b0;
        start_w  = 1'b0;
        lat = 0;
        while (((which == 0) ? !done_lz : !done_w) && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        dig = (which == 0) ? {4'd0, digit_lz} : digit_w;
        if (lat >= TIMEOUT) begin
            vec++; miscmp++;
            $display("FAIL alt_timeout which=%0d n=%0d", which, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;    number = '0;
        start_lz = 1'b0; number_lz = '0;
        start_w = 1'b0;  number_w = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({busy, done, ovf, digit_out} !== 11'd0) begin
            miscmp++;
            $display("FAIL reset_state got busy=%b done=%b ovf=%b dig=%h want all 0",
                     busy, done, ovf, digit_out);
        end
        vec++;
        if ({busy_w, done_w, ovf_w, digit_w} !== 15'd0) begin
            miscmp++;
            $display("FAIL reset_state_w got busy=%b done=%b ovf=%b dig=%h want all 0",
                     busy_w, done_w, ovf_w, digit_w);
        end
    endtask

    task automatic test_basic();
        logic [7:0] dig; logic ov; int lat, bc;
        run_conv(7'd59, dig, ov, lat, bc);
        vec++;
        if (dig !== 8'h59 || ov !== 1'b0) begin
            miscmp++;
            $display("FAIL basic_59 got %h ovf=%b want 59 ovf=0", dig, ov);
        end
        vec++;
        if (lat !== 8) begin
            miscmp++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        vec++;
        if (bc !== 8) begin
            miscmp++;
            $display("FAIL basic_busy_cycles got %0d want 8", bc);
        end
        // DONE must be a single-cycle pulse.
        @(negedge clk);
        vec++;
        if (done !== 1'b0 || digit_out !== 8'h59) begin
            miscmp++;
            $display("FAIL done_pulse got done=%b dig=%h want 0, 59 held", done, digit_out);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] dig; logic ov; int lat, bc;
        run_conv(7'd127, dig, ov, lat, bc);
        vec++;
        if (dig !== 8'hDD || ov !== 1'b1 || lat !== 8) begin
            miscmp++;
            $display("FAIL ovf_127 got %h ovf=%b lat=%0d want DD ovf=1 lat=8", dig, ov, lat);
        end
        run_conv(7'd99, dig, ov, lat, bc);
        vec++;
        if (dig !== 8'h99 || ov !== 1'b0) begin
            miscmp++;
            $display("FAIL ovf_99 got %h ovf=%b want 99 ovf=0", dig, ov);
        end
        run_conv(7'd100, dig, ov, lat, bc);
        vec++;
        if (dig !== 8'hDD || ov !== 1'b1) begin
            miscmp++;
            $display("FAIL ovf_100 got %h ovf=%b want DD ovf=1", dig, ov);
        end
    endtask

    task automatic test_lz_blank();
        logic [11:0] dig; logic [19:0] exp; int lat;
        int unsigned lz_vals[4] = '{0, 7, 10, 120};
        int unsigned w_vals[4]  = '{5, 999, 0, 1023};
        foreach (lz_vals[i]) begin
            run_alt(0, lz_vals[i], dig, lat);
            exp = ref_model(lz_vals[i], 2, 99, 1'b1);
            vec++;
            if (dig[7:0] !== exp[7:0] || ovf_lz !== (lz_vals[i] > 99)) begin
                miscmp++;
                $display("FAIL lz_%0d got %h ovf=%b want %h", lz_vals[i], dig[7:0], ovf_lz, exp[7:0]);
            end
        end
        foreach (w_vals[i]) begin
            run_alt(1, w_vals[i], dig, lat);
            exp = ref_model(w_vals[i], 3, 999, 1'b1);
            vec++;
            if (dig !== exp[11:0] || lat !== 11 || ovf_w !== (w_vals[i] > 999)) begin
                miscmp++;
                $display("FAIL wide_%0d got %h lat=%0d ovf=%b want %h lat=11",
                         w_vals[i], dig, lat, ovf_w, exp[11:0]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        number = 7'd59;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < TIMEOUT) begin
            if (lat == 2) begin number = 7'd42; start = 1'b1; end
            if (lat == 5) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        vec++;
        if (digit_out !== 8'h59 || lat !== 8) begin
            miscmp++;
            $display("FAIL busy_ignore got %h lat=%0d want 59 lat=8", digit_out, lat);
        end
        @(negedge clk);
        vec++;
        if (busy !== 1'b0) begin
            miscmp++;
            $display("FAIL busy_ignore_queued got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp; int gap;
        logic [6:0] n1, n2;
        n1 = 7'd37;
        n2 = 7'd84;
        @(negedge clk);
        number = n1;
        start  = 1'b1;
        gap = 0;
        @(negedge clk);
        while (!done && gap < TIMEOUT) begin @(negedge clk); gap++; end
        exp = ref_model(n1, 2, 99, 1'b0);
        vec++;
        if (digit_out !== exp[7:0]) begin
            miscmp++;
            $display("FAIL b2b_first got %h want %h", digit_out, exp[7:0]);
        end
        // START stays high, so the IDLE cycle that shows DONE accepts again.
        number = n2;
        @(negedge clk);
        gap = 1;
        vec++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscmp++;
            $display("FAIL b2b_accept got done=%b busy=%b want 0,1", done, busy);
        end
        start = 1'b0;
        while (!done && gap < TIMEOUT) begin @(negedge clk); gap++; end
        exp = ref_model(n2, 2, 99, 1'b0);
        // DONE to DONE = accept edge + 7 CONVERT edges + FINISH edge.
        vec++;
        if (digit_out !== exp[7:0] || gap !== 9) begin
            miscmp++;
            $display("FAIL b2b_second got %h gap=%0d want %h gap=9", digit_out, gap, exp[7:0]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] dig; logic ov; int lat, bc; int seen;
        @(negedge clk);
        number = 7'd59;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if (busy !== 1'b0 || digit_out !== 8'h00 || ovf !== 1'b0 || done !== 1'b0) begin
            miscmp++;
            $display("FAIL abort_state got busy=%b dig=%h ovf=%b done=%b want 0,00,0,0",
                     busy, digit_out, ovf, done);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        vec++;
        if (seen !== 0) begin
            miscmp++;
            $display("FAIL abort_no_done got %0d DONE pulses want 0", seen);
        end
        run_conv(7'd23, dig, ov, lat, bc);
        vec++;
        if (dig !== 8'h23 || ov !== 1'b0) begin
            miscmp++;
            $display("FAIL abort_then_23 got %h ovf=%b want 23 ovf=0", dig, ov);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] dig; logic ov; int lat, bc;
        logic [19:0] exp;
        for (int v = 0; v < 128; v++) begin
            run_conv(7'(v), dig, ov, lat, bc);
            exp = ref_model(v, 2, 99, 1'b0);
            vec++;
            if (dig !== exp[7:0] || ov !== (v > 99) || lat !== 8) begin
                miscmp++;
                $display("FAIL sweep_%0d got %h ovf=%b lat=%0d want %h ovf=%b lat=8",
                         v, dig, ov, lat, exp[7:0], (v > 99));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] dig; logic ov; int lat, bc;
        logic [19:0] exp;
        int unsigned v;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 127);
            run_conv(7'(v), dig, ov, lat, bc);
            exp = ref_model(v, 2, 99, 1'b0);
            vec++;
            if (dig !== exp[7:0] || ov !== (v > 99)) begin
                miscmp++;
                $display("FAIL random_%0d got %h ovf=%b want %h", v, dig, ov, exp[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_lz_blank();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
